dcache_if_pmem_mo: RTL

Parametrised successor of the single-outstanding dcache_if to pmem bridge. It accepts dcache_if requests from the LSU or dcache and buffers up to REQ_DEPTH of them. It issues up to MAX_OUTSTANDING reads and writes on the pmem (AXI-style) outport before waiting for responses, returning responses in order with their request tags. Cache-maintenance requests (invalidate, writeback, flush) are consumed and acknowledged locally, in order, without bus traffic. It also flags protocol violations on the outport response path.

---
 rtl/dcache_if_pmem_mo_pkg.sv | 27 ++
 rtl/dcache_if_pmem_mo_fifo.sv | 62 ++++++
 rtl/dcache_if_pmem_mo.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dcache_if_pmem_mo_pkg.sv
// rtl/dcache_if_pmem_mo_pkg.sv - shared constants for the dcache_if to pmem bridge
// Request word layout, outstanding counter width and a depth helper.
package dcache_if_pmem_mo_pkg;

  localparam int REQ_W    = 70;
  localparam int DROP_BIT = 69;
  localparam int RD_BIT   = 68;
  localparam int WR_MSB   = 67;
  localparam int WR_LSB   = 64;
  localparam int DATA_MSB = 63;
  localparam int DATA_LSB = 32;
  localparam int ADDR_MSB = 31;
  localparam int ADDR_LSB = 0;

  localparam int OUT_W = 4;

  // Smallest power of two that is >= n.
  function automatic int pow2_ceil(input int n);
    int p;
    p = 1;
    for (int i = 0; i < 31; i++) begin
      if (p < n) p = p * 2;
    end
    return p;
  endfunction

endpackage

// File: rtl/dcache_if_pmem_mo_fifo.sv
// rtl/dcache_if_pmem_mo_fifo.sv - generic synchronous FIFO with registered count
// Full/empty come from the registered count only, so a pop never frees space in the same cycle.
module dcache_if_pmem_mo_fifo
  import dcache_if_pmem_mo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [WIDTH-1:0]  data_i,
  output logic              accept_o,
  input  logic              pop_i,
  output logic              valid_o,
  output logic [WIDTH-1:0]  data_o,
  output logic [ADDR_W:0]   count_o
);

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              do_push, do_pop;

  assign accept_o = (count_q != FULL);
  assign valid_o  = (count_q != '0);
  assign do_push  = push_i & accept_o;
  assign do_pop   = pop_i & valid_o;
  assign data_o   = mem_q[rd_ptr_q];
  assign count_o  = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/dcache_if_pmem_mo.sv
// rtl/dcache_if_pmem_mo.sv - multi-outstanding dcache_if to pmem bridge
// Buffers requests, issues up to MAX_OUTSTANDING bus transactions, acks maintenance ops locally.
module dcache_if_pmem_mo
  import dcache_if_pmem_mo_pkg::*;
#(
  parameter int REQ_DEPTH       = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter int TAG_W           = 11
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [31:0]      mem_addr_i,
  input  logic [31:0]      mem_data_wr_i,
  input  logic             mem_rd_i,
  input  logic [3:0]       mem_wr_i,
  input  logic             mem_cacheable_i,
  input  logic [TAG_W-1:0] mem_req_tag_i,
  input  logic             mem_invalidate_i,
  input  logic             mem_writeback_i,
  input  logic             mem_flush_i,
  output logic [31:0]      mem_data_rd_o,
  output logic             mem_accept_o,
  output logic             mem_ack_o,
  output logic             mem_error_o,
  output logic [TAG_W-1:0] mem_resp_tag_o,
  output logic [3:0]       outport_wr_o,
  output logic             outport_rd_o,
  output logic [7:0]       outport_len_o,
  output logic [31:0]      outport_addr_o,
  output logic [31:0]      outport_write_data_o,
  input  logic             outport_accept_i,
  input  logic             outport_ack_i,
  input  logic             outport_error_i,
  input  logic [31:0]      outport_read_data_i,
  output logic [3:0]       outstanding_o,
  output logic             unexpected_ack_o
);

  localparam int RESP_DEPTH = pow2_ceil(REQ_DEPTH + MAX_OUTSTANDING);
  localparam int REQ_AW     = $clog2(REQ_DEPTH);
  localparam int RESP_AW    = $clog2(RESP_DEPTH);
  localparam logic [OUT_W-1:0] MAX_OUT = OUT_W'(MAX_OUTSTANDING);

  logic             req_drop, req_any, push;
  logic [REQ_W-1:0] req_word, head;
  logic             req_accept, head_valid, tag_accept;
  logic             tag_valid_unused;
  logic [REQ_AW:0]  req_count_unused;
  logic [RESP_AW:0] tag_count_unused;
  logic             unused_bits;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             drop_ack_q, drop_ack_d;
  logic             unexpected_q, unexpected_d;
  logic             head_drop, can_issue, issue, drop_pop, ack_dec;

  assign req_drop = mem_invalidate_i | mem_writeback_i | mem_flush_i;
  assign req_any  = mem_rd_i | (|mem_wr_i) | req_drop;
  assign req_word = {req_drop, mem_rd_i, mem_wr_i, mem_data_wr_i, mem_addr_i};
  assign mem_accept_o = req_accept & tag_accept;
  assign push     = req_any & mem_accept_o;

  dcache_if_pmem_mo_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (REQ_DEPTH),
    .ADDR_W(REQ_AW)
  ) u_req_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (req_word),
    .accept_o(req_accept),
    .pop_i   (issue | drop_pop),
    .valid_o (head_valid),
    .data_o  (head),
    .count_o (req_count_unused)
  );

  // Tags leave in request order; every ack (bus or local) consumes one.
  dcache_if_pmem_mo_fifo #(
    .WIDTH (TAG_W),
    .DEPTH (RESP_DEPTH),
    .ADDR_W(RESP_AW)
  ) u_tag_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .data_i  (mem_req_tag_i),
    .accept_o(tag_accept),
    .pop_i   (mem_ack_o),
    .valid_o (tag_valid_unused),
    .data_o  (mem_resp_tag_o),
    .count_o (tag_count_unused)
  );

  assign head_drop = head[DROP_BIT];
  assign can_issue = head_valid & ~head_drop & (outstanding_q < MAX_OUT) & ~drop_ack_q;
  assign issue     = can_issue & outport_accept_i;
  // Maintenance ops act as a barrier: all earlier bus traffic must be acked first.
  assign drop_pop  = head_valid & head_drop & (outstanding_q == '0) & ~drop_ack_q;
  assign ack_dec   = outport_ack_i & (outstanding_q != '0);

  assign outport_rd_o         = can_issue & head[RD_BIT];
  assign outport_wr_o         = can_issue ? head[WR_MSB:WR_LSB] : 4'b0;
  assign outport_addr_o       = can_issue ? {head[ADDR_MSB:ADDR_LSB+2], 2'b00} : 32'b0;
  assign outport_write_data_o = can_issue ? head[DATA_MSB:DATA_LSB] : 32'b0;
  assign outport_len_o        = 8'b0;

  assign mem_ack_o        = drop_ack_q | outport_ack_i;
  assign mem_error_o      = outport_error_i & outport_ack_i;
  assign mem_data_rd_o    = outport_read_data_i;
  assign outstanding_o    = outstanding_q;
  assign unexpected_ack_o = unexpected_q;
  assign unused_bits      = &{1'b0, mem_cacheable_i, head[ADDR_LSB+1:ADDR_LSB],
                              tag_valid_unused, req_count_unused, tag_count_unused};

  always_comb begin
    outstanding_d = outstanding_q;
    if (issue && !ack_dec)      outstanding_d = outstanding_q + 1'b1;
    else if (!issue && ack_dec) outstanding_d = outstanding_q - 1'b1;
    drop_ack_d   = drop_pop;
    unexpected_d = unexpected_q | (outport_ack_i & (outstanding_q == '0));
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      drop_ack_q    <= 1'b0;
      unexpected_q  <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      drop_ack_q    <= drop_ack_d;
      unexpected_q  <= unexpected_d;
    end
  end

endmodule
